// File: rtl/fb_pkg.sv
// Shared framebuffer geometry and grant encoding for the scanout/writer arbiter.
package fb_pkg;

   localparam int unsigned PIX_W     = 2;
   localparam int unsigned H_PIX     = 160;
   localparam int unsigned V_PIX     = 144;
   localparam int unsigned ADDR_W    = 15;
   localparam int unsigned FB_PIXELS = H_PIX * V_PIX;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_RD   = 2'd1,
      GNT_WR   = 2'd2
   } gnt_e;

endpackage

// File: rtl/fb_pix_fifo.sv
// Prefetch FIFO between the RAM read port and the DVI pixel path.
module fb_pix_fifo
   import fb_pkg::*;
#(
   parameter int unsigned WIDTH = PIX_W,
   parameter int unsigned DEPTH = 8,
   localparam int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_rst_b,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_pop_data,
   output logic [PTR_W:0]   o_count,
   output logic             o_empty,
   output logic             o_full
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_count    = r_count;
   assign o_empty    = (r_count == '0);
   assign o_full     = (r_count == (PTR_W + 1)'(DEPTH));
   assign w_do_pop   = i_pop & ~o_empty;
   // A pop frees a slot in the same cycle, so push-while-full is legal only with a pop.
   assign w_do_push  = i_push & (~o_full | w_do_pop);
   assign o_pop_data = o_empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge i_clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_b || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count <= r_count + (PTR_W + 1)'(w_do_push) - (PTR_W + 1)'(w_do_pop);
      end
   end

endmodule

// File: rtl/fb_mem_arbiter.sv
// Single-port framebuffer RAM shared between scanout prefetch reads and posted LCD writes.
module fb_mem_arbiter
   import fb_pkg::*;
#(
   parameter int unsigned LINE_REPEAT = 3,
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter int unsigned LOW_WATER   = 2,
   parameter int unsigned MAX_WAIT    = 4
) (
   input  logic              fbclk,
   input  logic              fbclk_rst_b,
   input  logic              frame_start,
   input  logic              pix_pop,
   output logic [PIX_W-1:0]  pix_data,
   output logic              pix_valid,
   output logic              underflow,
   input  logic              gb_wr_valid,
   output logic              gb_wr_ready,
   input  logic [ADDR_W-1:0] gb_wr_addr,
   input  logic [PIX_W-1:0]  gb_wr_data,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [PIX_W-1:0]  ram_wdata,
   input  logic [PIX_W-1:0]  ram_rdata
);

   localparam int unsigned XW = $clog2(H_PIX);
   localparam int unsigned YW = $clog2(V_PIX);
   localparam int unsigned RW = (LINE_REPEAT > 1) ? $clog2(LINE_REPEAT) : 1;
   localparam int unsigned WW = $clog2(MAX_WAIT + 1);
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   logic              r_gen_active;
   logic [XW-1:0]     r_x;
   logic [RW-1:0]     r_rep;
   logic [YW-1:0]     r_y;
   logic [ADDR_W-1:0] r_line_base;
   logic              r_inflight;
   logic [WW-1:0]     r_wait_cnt;
   logic              r_underflow;

   logic [ADDR_W-1:0] w_gen_addr;
   logic              w_x_last, w_rep_last, w_y_last;
   logic [CW-1:0]     w_count, w_occ, w_space;
   logic              w_fifo_empty, w_fifo_full;
   logic              w_rd_ok, w_urgent, w_forced, w_wr_in_range, w_wr_do;
   gnt_e              w_gnt;

   assign w_gen_addr = r_line_base + ADDR_W'(r_x);
   assign w_x_last   = (r_x == XW'(H_PIX - 1));
   assign w_rep_last = (r_rep == RW'(LINE_REPEAT - 1));
   assign w_y_last   = (r_y == YW'(V_PIX - 1));

   // Inflight reads already own a FIFO slot, so they count against space.
   assign w_occ    = w_count + CW'(r_inflight);
   assign w_space  = CW'(FIFO_DEPTH) - w_occ;
   assign w_rd_ok  = r_gen_active & ~w_fifo_full & (w_space != '0);
   assign w_urgent = (w_occ < CW'(LOW_WATER));
   assign w_forced = gb_wr_valid & (r_wait_cnt >= WW'(MAX_WAIT));

   always_comb begin
      w_gnt = GNT_NONE;
      if (!fbclk_rst_b || frame_start) w_gnt = GNT_NONE;
      else if (w_rd_ok && w_urgent)    w_gnt = GNT_RD;
      else if (w_forced)               w_gnt = GNT_WR;
      else if (w_rd_ok)                w_gnt = GNT_RD;
      else if (gb_wr_valid)            w_gnt = GNT_WR;
   end

   assign w_wr_in_range = (gb_wr_addr < ADDR_W'(FB_PIXELS));
   assign gb_wr_ready   = (w_gnt == GNT_WR);
   assign w_wr_do       = gb_wr_ready & w_wr_in_range;

   always_comb begin
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      if (w_gnt == GNT_RD) begin
         ram_en   = 1'b1;
         ram_addr = w_gen_addr;
      end else if (w_wr_do) begin
         ram_en    = 1'b1;
         ram_we    = 1'b1;
         ram_addr  = gb_wr_addr;
         ram_wdata = gb_wr_data;
      end
   end

   always_ff @(posedge fbclk) begin
      if (!fbclk_rst_b) begin
         r_gen_active <= 1'b0;
         r_x          <= '0;
         r_rep        <= '0;
         r_y          <= '0;
         r_line_base  <= '0;
         r_inflight   <= 1'b0;
         r_wait_cnt   <= '0;
         r_underflow  <= 1'b0;
      end else begin
         r_inflight <= (w_gnt == GNT_RD);
         if (!gb_wr_valid || gb_wr_ready) r_wait_cnt <= '0;
         else if (r_wait_cnt < WW'(MAX_WAIT)) r_wait_cnt <= r_wait_cnt + WW'(1);
         if (frame_start) r_underflow <= 1'b0;
         else if (pix_pop && w_fifo_empty) r_underflow <= 1'b1;

         if (frame_start) begin
            r_gen_active <= 1'b1;
            r_x          <= '0;
            r_rep        <= '0;
            r_y          <= '0;
            r_line_base  <= '0;
         end else if (w_gnt == GNT_RD) begin
            if (!w_x_last) begin
               r_x <= r_x + XW'(1);
            end else begin
               r_x <= '0;
               if (!w_rep_last) begin
                  r_rep <= r_rep + RW'(1);
               end else begin
                  r_rep <= '0;
                  if (w_y_last) begin
                     r_gen_active <= 1'b0;
                     r_y          <= '0;
                     r_line_base  <= '0;
                  end else begin
                     r_y         <= r_y + YW'(1);
                     r_line_base <= r_line_base + ADDR_W'(H_PIX);
                  end
               end
            end
         end
      end
   end

   assign underflow = r_underflow;
   assign pix_valid = ~w_fifo_empty;

   // Flush wins over the push of a read issued before frame_start, discarding it.
   fb_pix_fifo #(
      .WIDTH(PIX_W),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .i_clk       (fbclk),
      .i_rst_b     (fbclk_rst_b),
      .i_flush     (frame_start),
      .i_push      (r_inflight),
      .i_push_data (ram_rdata),
      .i_pop       (pix_pop),
      .o_pop_data  (pix_data),
      .o_count     (w_count),
      .o_empty     (w_fifo_empty),
      .o_full      (w_fifo_full)
   );

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Directed bench for fb_mem_arbiter with a behavioural single-port RAM.
module tb_fb_mem_arbiter;

   localparam int FB = 23040;

   logic        fbclk = 1'b0;
   logic        fbclk_rst_b, frame_start, pix_pop, gb_wr_valid;
   logic [14:0] gb_wr_addr;
   logic [1:0]  gb_wr_data, ram_rdata;
   logic [1:0]  pix_data, ram_wdata;
   logic        pix_valid, underflow, gb_wr_ready, ram_en, ram_we;
   logic [14:0] ram_addr;

   logic [1:0] mem [FB];
   bit         wr_seen [FB];

   int n_checks = 0;
   int n_errs   = 0;

   int ex_x = 0, ex_rep = 0, ex_y = 0;
   int q[$];
   int reads = 0, pops = 0, aerr = 0, derr = 0, last_addr = -1;
   bit done = 1'b0;

   always #5 fbclk = ~fbclk;

   fb_mem_arbiter u_dut (
      .fbclk       (fbclk),
      .fbclk_rst_b (fbclk_rst_b),
      .frame_start (frame_start),
      .pix_pop     (pix_pop),
      .pix_data    (pix_data),
      .pix_valid   (pix_valid),
      .underflow   (underflow),
      .gb_wr_valid (gb_wr_valid),
      .gb_wr_ready (gb_wr_ready),
      .gb_wr_addr  (gb_wr_addr),
      .gb_wr_data  (gb_wr_data),
      .ram_en      (ram_en),
      .ram_we      (ram_we),
      .ram_addr    (ram_addr),
      .ram_wdata   (ram_wdata),
      .ram_rdata   (ram_rdata)
   );

   function automatic logic [1:0] pat(input int a);
      return 2'((a * 5 + a / 160 + 1) & 3);
   endfunction

   always @(posedge fbclk) begin
      if (ram_en && !ram_we)
         ram_rdata <= wr_seen[ram_addr] ? mem[ram_addr] : pat(int'(ram_addr));
      if (ram_en && ram_we) begin
         mem[ram_addr]     <= ram_wdata;
         wr_seen[ram_addr] <= 1'b1;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge fbclk);
      #1;
   endtask

   function automatic int exp_addr();
      return ex_y * 160 + ex_x;
   endfunction

   function automatic void advance();
      ex_x++;
      if (ex_x == 160) begin
         ex_x = 0;
         ex_rep++;
         if (ex_rep == 3) begin
            ex_rep = 0;
            ex_y++;
         end
      end
   endfunction

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_ram_en"}, 32'(ram_en), 0);
      check_eq({tag, "_ram_we"}, 32'(ram_we), 0);
      check_eq({tag, "_ram_addr"}, 32'(ram_addr), 0);
      check_eq({tag, "_ram_wdata"}, 32'(ram_wdata), 0);
      check_eq({tag, "_pix_valid"}, 32'(pix_valid), 0);
      check_eq({tag, "_pix_data"}, 32'(pix_data), 0);
      check_eq({tag, "_underflow"}, 32'(underflow), 0);
      check_eq({tag, "_wr_ready"}, 32'(gb_wr_ready), 0);
   endtask

   initial begin
      fbclk_rst_b = 1'b0;
      frame_start = 1'b0;
      pix_pop     = 1'b0;
      gb_wr_valid = 1'b0;
      gb_wr_addr  = '0;
      gb_wr_data  = '0;
      repeat (3) tick();
      #1 check_all_zero("rst");
      fbclk_rst_b = 1'b1;
      tick();
      #1 check_eq("idle_before_fs", 32'(ram_en), 0);

      // Fill after frame_start: reads 0..7 back to back, then stall while full
      frame_start = 1'b1;
      #1 check_eq("t1_fs_no_gnt", 32'(ram_en), 0);
      tick();
      frame_start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         check_eq("t1_rd_en", 32'({ram_en, ram_we}), 32'd2);
         check_eq("t1_rd_addr", 32'(ram_addr), 32'(exp_addr()));
         q.push_back(exp_addr());
         advance();
         reads++;
         if (i == 1) check_eq("t1_valid_lat", 32'(pix_valid), 0);
         if (i == 2) begin
            check_eq("t1_valid", 32'(pix_valid), 1);
            check_eq("t1_data0", 32'(pix_data), 32'(pat(0)));
         end
         tick();
      end
      #1 check_eq("t1_full_stall", 32'(ram_en), 0);
      tick();
      #1 check_eq("t1_full_stall2", 32'(ram_en), 0);
      check_eq("t1_full_valid", 32'(pix_valid), 1);

      // Whole frame with the pixel path draining
      for (int c = 0; c < 80000 && !done; c++) begin
         tick();
         pix_pop = pix_valid;
         #1;
         if (pix_pop) begin
            if (q.size() == 0) derr++;
            else if (pix_data !== pat(q.pop_front())) derr++;
            pops++;
         end
         if (ram_en && !ram_we) begin
            if (int'(ram_addr) != exp_addr()) aerr++;
            last_addr = int'(ram_addr);
            q.push_back(exp_addr());
            advance();
            reads++;
         end
         if (reads == 69120 && q.size() == 0) done = 1'b1;
      end
      tick();
      pix_pop = 1'b0;
      check_eq("t2_done", 32'(done), 1);
      check_eq("t2_reads", 32'(reads), 69120);
      check_eq("t2_pops", 32'(pops), 69120);
      check_eq("t2_addr_errs", 32'(aerr), 0);
      check_eq("t2_data_errs", 32'(derr), 0);
      check_eq("t2_last_addr", 32'(last_addr), 23039);
      #1 check_eq("t2_underflow", 32'(underflow), 0);
      check_eq("t2_gen_idle", 32'(ram_en), 0);
      check_eq("t2_drained", 32'(pix_valid), 0);

      // Write with FIFO full is granted at once
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      repeat (10) tick();
      #1 check_eq("t3_full", 32'({pix_valid, ram_en}), 32'd2);
      gb_wr_valid = 1'b1;
      gb_wr_addr  = 15'd100;
      gb_wr_data  = 2'd3;
      #1;
      check_eq("t3_wr_ready", 32'(gb_wr_ready), 1);
      check_eq("t3_wr_en_we", 32'({ram_en, ram_we}), 32'd3);
      check_eq("t3_wr_addr", 32'(ram_addr), 100);
      check_eq("t3_wr_data", 32'(ram_wdata), 3);
      tick();
      gb_wr_valid = 1'b0;
      pix_pop     = 1'b1;
      repeat (3) tick();
      // Reads stay eligible, so the write waits MAX_WAIT cycles then is forced
      gb_wr_valid = 1'b1;
      gb_wr_addr  = 15'd200;
      gb_wr_data  = 2'd1;
      for (int k = 0; k < 4; k++) begin
         #1;
         check_eq("t3_refused", 32'(gb_wr_ready), 0);
         check_eq("t3_refused_rd", 32'({ram_en, ram_we}), 32'd2);
         tick();
      end
      #1;
      check_eq("t3_forced_ready", 32'(gb_wr_ready), 1);
      check_eq("t3_forced_we", 32'({ram_en, ram_we}), 32'd3);
      check_eq("t3_forced_addr", 32'(ram_addr), 200);
      check_eq("t3_forced_data", 32'(ram_wdata), 1);
      tick();
      gb_wr_valid = 1'b0;
      tick();

      // Saturated wait_cnt across frame_start still loses to urgent reads
      gb_wr_valid = 1'b1;
      gb_wr_addr  = 15'd300;
      gb_wr_data  = 2'd2;
      for (int k = 0; k < 3; k++) begin
         #1 check_eq("t4_refused", 32'(gb_wr_ready), 0);
         tick();
      end
      frame_start = 1'b1;
      pix_pop     = 1'b0;
      #1 check_eq("t4_fs_no_gnt", 32'({ram_en, gb_wr_ready}), 0);
      tick();
      frame_start = 1'b0;
      #1;
      check_eq("t4_urgent_rd", 32'({ram_en, ram_we, gb_wr_ready}), 32'd4);
      check_eq("t6_first_addr", 32'(ram_addr), 0);
      check_eq("t6_flushed", 32'(pix_valid), 0);
      tick();
      #1;
      check_eq("t4_urgent_rd2", 32'({ram_en, ram_we, gb_wr_ready}), 32'd4);
      check_eq("t4_urgent_addr2", 32'(ram_addr), 1);
      check_eq("t6_discarded", 32'(pix_valid), 0);
      tick();
      #1;
      check_eq("t4_wr_ready", 32'(gb_wr_ready), 1);
      check_eq("t4_wr_we", 32'({ram_en, ram_we}), 32'd3);
      check_eq("t4_wr_addr", 32'(ram_addr), 300);
      check_eq("t4_wr_data", 32'(ram_wdata), 2);
      tick();
      gb_wr_valid = 1'b0;

      // Underflow is sticky; out-of-range write is accepted but dropped
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      pix_pop     = 1'b1;
      #1 check_eq("t5_empty", 32'(pix_valid), 0);
      tick();
      pix_pop = 1'b0;
      #1 check_eq("t5_underflow", 32'(underflow), 1);
      repeat (4) tick();
      #1 check_eq("t5_sticky", 32'(underflow), 1);
      repeat (8) tick();
      #1 check_eq("t5_full", 32'({pix_valid, ram_en}), 32'd2);
      gb_wr_valid = 1'b1;
      gb_wr_addr  = 15'd23040;
      gb_wr_data  = 2'd3;
      #1;
      check_eq("t5_oor_ready", 32'(gb_wr_ready), 1);
      check_eq("t5_oor_dropped", 32'({ram_en, ram_we}), 0);
      tick();
      gb_wr_valid = 1'b0;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      #1 check_eq("t5_cleared", 32'(underflow), 0);

      // Reset mid-frame
      pix_pop = 1'b1;
      tick();
      pix_pop = 1'b0;
      repeat (4) tick();
      #1;
      check_eq("t6_pre_underflow", 32'(underflow), 1);
      check_eq("t6_pre_valid", 32'(pix_valid), 1);
      fbclk_rst_b = 1'b0;
      tick();
      #1 check_all_zero("t6_rst");
      fbclk_rst_b = 1'b1;
      tick();
      #1 check_eq("t6_idle_after_rst", 32'(ram_en), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule
